wb_mc_dma_8bit_fifo: RTL

Multi-channel Wishbone DMA engine moving data between 32-bit system memory and byte-wide FIFOs in the USB mass-storage subsystem. It replaces the separate single-channel FIFO reader and writer DMA engines plus their demux arbiter. It provides CH_N channels, each selectable at start time as memory→FIFO or FIFO→memory. One shared bus master serves the channels round-robin, one word per grant.

---
 rtl/wb_mc_dma_8bit_fifo_if.sv | 15 +
 rtl/wb_mc_dma_8bit_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mc_dma_8bit_fifo_if.sv
// Classic single-cycle Wishbone bus: 32-bit address and data, 4-bit byte select.
interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;

    modport mst (output cyc, stb, we, adr, wdat, sel, input rdat, ack, err);
    modport slv (input cyc, stb, we, adr, wdat, sel, output rdat, ack, err);
endinterface

// File: rtl/wb_mc_dma_8bit_fifo.sv
// Multi-channel Wishbone DMA between 32-bit memory and byte-wide FIFOs, round-robin one word per grant.
// Optional feature: define USB_DMA_ABORT_EN to add per-channel abort_i (stop at next word boundary).
module wb_mc_dma_8bit_fifo #(
    parameter int CH_N  = 2,
    parameter int LEN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_if.mst                     wbm,
    input  logic [CH_N-1:0]       start_i,
    input  logic [CH_N-1:0]       dir_i,
    input  logic [CH_N*32-1:0]    start_adr_i,
    input  logic [CH_N*LEN_W-1:0] data_len_i,
`ifdef USB_DMA_ABORT_EN
    input  logic [CH_N-1:0]       abort_i,
`endif
    output logic [CH_N-1:0]       idle_o,
    output logic [CH_N-1:0]       done_stb_o,
    output logic [CH_N-1:0]       err_o,
    input  logic [CH_N-1:0]       fifo_ready_i,
    output logic [CH_N-1:0]       fifo_wr_o,
    output logic [CH_N*8-1:0]     fifo_wdat_o,
    output logic [CH_N-1:0]       fifo_rd_o,
    input  logic [CH_N*8-1:0]     fifo_rdat_i
);
    localparam int IDX_W = (CH_N > 1) ? $clog2(CH_N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_FILL, S_BUS, S_DRAIN} state_t;

    state_t            state_r;
    logic [CH_N-1:0]   idle_r, dir_r, err_r, done_r, wr_r, rd_r;
    logic [CH_N*8-1:0] wdat_r;
    logic [31:0]       ch_adr_r [CH_N];
    logic [LEN_W-1:0]  ch_rem_r [CH_N];
    logic [IDX_W-1:0]  grant_r, last_r;
    logic [2:0]        nb_r;
    logic [1:0]        cnt_r;
    logic [31:0]       word_r;
    logic              cyc_r, stb_r, we_r;
    logic [31:0]       adr_r, dat_r;
    logic [3:0]        sel_r;
`ifdef USB_DMA_ABORT_EN
    logic [CH_N-1:0]   abort_r;
    logic              active_s;
`endif

    logic [CH_N-1:0]   elig_s;
    logic              found_s;
    logic [IDX_W-1:0]  pick_s;
    logic [2:0]        pick_nb_s;
    logic [7:0]        g_rdat_s;
    logic [LEN_W-1:0]  rem_next_s;
    logic              last_word_s;
    logic              last_byte_s;
    logic [31:0]       fill_word_s;

    function automatic logic [2:0] nb_of(input logic [LEN_W-1:0] rem);
        return (rem[LEN_W-1:2] != '0) ? 3'd4 : {1'b0, rem[1:0]};
    endfunction

    function automatic logic [3:0] sel_of(input logic [2:0] nb);
        case (nb)
            3'd1:    return 4'h1;
            3'd2:    return 4'h3;
            3'd3:    return 4'h7;
            3'd4:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k, input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Channels competing for the bus this cycle
    always_comb begin
        for (int c = 0; c < CH_N; c++) begin
`ifdef USB_DMA_ABORT_EN
            elig_s[c] = !idle_r[c] && fifo_ready_i[c] && !abort_r[c];
`else
            elig_s[c] = !idle_r[c] && fifo_ready_i[c];
`endif
        end
    end

    // Round-robin search beginning just after the previous grantee
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        for (int i = 1; i <= CH_N; i++) begin
            int   c;
            logic hit;
            c       = int'(last_r) + i;
            c       = (c >= CH_N) ? c - CH_N : c;
            hit     = !found_s && elig_s[c];
            pick_s  = hit ? c[IDX_W-1:0] : pick_s;
            found_s = found_s | hit;
        end
    end

    // Per-word bookkeeping for the granted channel
    always_comb begin
        pick_nb_s   = nb_of(ch_rem_r[pick_s]);
        g_rdat_s    = fifo_rdat_i[int'(grant_r)*8 +: 8];
        rem_next_s  = ch_rem_r[grant_r] - {{(LEN_W-3){1'b0}}, nb_r};
        last_byte_s = (({1'b0, cnt_r} + 3'd1) == nb_r);
        fill_word_s = put_byte(word_r, cnt_r, g_rdat_s);
`ifdef USB_DMA_ABORT_EN
        active_s    = (state_r == S_FILL) || (state_r == S_BUS) || (state_r == S_DRAIN);
        last_word_s = (rem_next_s == '0) || abort_r[grant_r];
`else
        last_word_s = (rem_next_s == '0);
`endif
    end

    // Channel bookkeeping and the shared bus/FIFO engine
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
            idle_r  <= '1;
            dir_r   <= '0;
            err_r   <= '0;
            done_r  <= '0;
            wr_r    <= '0;
            rd_r    <= '0;
            wdat_r  <= '0;
            grant_r <= '0;
            last_r  <= '0;
            nb_r    <= 3'd0;
            cnt_r   <= 2'd0;
            word_r  <= 32'h0;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= 32'h0;
            dat_r   <= 32'h0;
            sel_r   <= 4'h0;
`ifdef USB_DMA_ABORT_EN
            abort_r <= '0;
`endif
            for (int c = 0; c < CH_N; c++) begin
                ch_adr_r[c] <= 32'h0;
                ch_rem_r[c] <= '0;
            end
        end else begin
            done_r <= '0;
            for (int c = 0; c < CH_N; c++) begin
                if (idle_r[c] && start_i[c]) begin
                    err_r[c]    <= 1'b0;
                    dir_r[c]    <= dir_i[c];
                    ch_adr_r[c] <= start_adr_i[c*32 +: 32];
                    ch_rem_r[c] <= data_len_i[c*LEN_W +: LEN_W];
`ifdef USB_DMA_ABORT_EN
                    abort_r[c]  <= 1'b0;
`endif
                    // A zero-length transfer completes without ever leaving idle
                    if (data_len_i[c*LEN_W +: LEN_W] == '0) begin
                        done_r[c] <= 1'b1;
                    end else begin
                        idle_r[c] <= 1'b0;
                    end
                end
`ifdef USB_DMA_ABORT_EN
                else if (!idle_r[c] && abort_r[c] && !(active_s && (c == int'(grant_r)))) begin
                    idle_r[c]  <= 1'b1;
                    done_r[c]  <= 1'b1;
                    abort_r[c] <= 1'b0;
                end else if (!idle_r[c] && abort_i[c]) begin
                    abort_r[c] <= 1'b1;
                end
`endif
            end

            case (state_r)
                S_IDLE: begin
                    if (idle_r != '1) state_r <= S_ARB;
                end
                S_ARB: begin
                    if (found_s) begin
                        grant_r <= pick_s;
                        last_r  <= pick_s;
                        nb_r    <= pick_nb_s;
                        cnt_r   <= 2'd0;
                        word_r  <= 32'h0;
                        if (dir_r[pick_s]) begin
                            rd_r[pick_s] <= 1'b1;
                            state_r      <= S_FILL;
                        end else begin
                            cyc_r   <= 1'b1;
                            stb_r   <= 1'b1;
                            we_r    <= 1'b0;
                            adr_r   <= {ch_adr_r[pick_s][31:2], 2'b00};
                            sel_r   <= sel_of(pick_nb_s);
                            state_r <= S_BUS;
                        end
                    end else if (idle_r == '1) begin
                        state_r <= S_IDLE;
                    end
                end
                S_FILL: begin
                    word_r <= fill_word_s;
                    if (last_byte_s) begin
                        rd_r[grant_r] <= 1'b0;
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        we_r    <= 1'b1;
                        adr_r   <= {ch_adr_r[grant_r][31:2], 2'b00};
                        sel_r   <= sel_of(nb_r);
                        dat_r   <= fill_word_s;
                        state_r <= S_BUS;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                S_BUS: begin
                    if (wbm.err) begin
                        cyc_r           <= 1'b0;
                        stb_r           <= 1'b0;
                        we_r            <= 1'b0;
                        err_r[grant_r]  <= 1'b1;
                        idle_r[grant_r] <= 1'b1;
                        done_r[grant_r] <= 1'b1;
`ifdef USB_DMA_ABORT_EN
                        abort_r[grant_r] <= 1'b0;
`endif
                        state_r <= S_ARB;
                    end else if (wbm.ack) begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
                        we_r  <= 1'b0;
                        if (dir_r[grant_r]) begin
                            ch_adr_r[grant_r] <= ch_adr_r[grant_r] + 32'd4;
                            ch_rem_r[grant_r] <= rem_next_s;
                            if (last_word_s) begin
                                idle_r[grant_r] <= 1'b1;
                                done_r[grant_r] <= 1'b1;
`ifdef USB_DMA_ABORT_EN
                                abort_r[grant_r] <= 1'b0;
`endif
                            end
                            state_r <= S_ARB;
                        end else begin
                            word_r  <= wbm.rdat;
                            cnt_r   <= 2'd0;
                            wr_r[grant_r] <= 1'b1;
                            wdat_r[int'(grant_r)*8 +: 8] <= wbm.rdat[7:0];
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_byte_s) begin
                        wr_r[grant_r]     <= 1'b0;
                        ch_adr_r[grant_r] <= ch_adr_r[grant_r] + 32'd4;
                        ch_rem_r[grant_r] <= rem_next_s;
                        if (last_word_s) begin
                            idle_r[grant_r] <= 1'b1;
                            done_r[grant_r] <= 1'b1;
`ifdef USB_DMA_ABORT_EN
                            abort_r[grant_r] <= 1'b0;
`endif
                        end
                        state_r <= S_ARB;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                        wdat_r[int'(grant_r)*8 +: 8] <= get_byte(word_r, cnt_r + 2'd1);
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign idle_o      = idle_r;
    assign done_stb_o  = done_r;
    assign err_o       = err_r;
    assign fifo_wr_o   = wr_r;
    assign fifo_wdat_o = wdat_r;
    assign fifo_rd_o   = rd_r;
    assign wbm.cyc     = cyc_r;
    assign wbm.stb     = stb_r;
    assign wbm.we      = we_r;
    assign wbm.adr     = adr_r;
    assign wbm.wdat    = dat_r;
    assign wbm.sel     = sel_r;
endmodule
